// File: rtl/cache_fill_if.sv
// Bundle of the cache-fill controller's cache-side and memory-side signals.
// The controller uses the slave modport. The cache/memory environment uses the master modport.
//
// Handshake semantics, applying to every transfer on this bundle:
//   - mem_en is a one-cycle read request strobe carrying memory_address.
//     Memory always accepts it, so there is no ready/backpressure.
//   - memory_data_valid qualifies memory_data for exactly the cycle it is
//     high. The controller always accepts the word in that cycle (no ready).
//   - write_data_array / write_tag_array / fill_done are single-cycle
//     strobes qualified by themselves; the arrays always accept them.
//   - miss_detected is a level, sampled only while the controller is idle.
interface cache_fill_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic [DATA_W-1:0] memory_data;
    logic              memory_data_valid;
    logic              fsm_busy;
    logic              mem_en;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [2:0]        cache_word_offset;
    logic [DATA_W-1:0] fill_data;
    logic              write_tag_array;
    logic              fill_done;
    // Debug view of the controller state: 0 = IDLE, 1 = FILL.
    logic              fsm_state_dbg;

    modport master (
        output miss_detected,
        output miss_address,
        output memory_data,
        output memory_data_valid,
        input  fsm_busy,
        input  mem_en,
        input  memory_address,
        input  write_data_array,
        input  cache_word_offset,
        input  fill_data,
        input  write_tag_array,
        input  fill_done,
        input  fsm_state_dbg
    );

    modport slave (
        input  miss_detected,
        input  miss_address,
        input  memory_data,
        input  memory_data_valid,
        output fsm_busy,
        output mem_en,
        output memory_address,
        output write_data_array,
        output cache_word_offset,
        output fill_data,
        output write_tag_array,
        output fill_done,
        output fsm_state_dbg
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller.
// On a miss it stalls the pipeline and requests the 8 words of the 16-byte block
// in 8 back-to-back cycles. Each returned word is written into the data array at
// the next offset. The tag/valid entry is written together with the 8th word.
// Returned words may arrive with gaps and may overlap the request phase.
module cache_fill_fsm #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input logic        clk,
    input logic        rst,
    cache_fill_if.slave bus
);

    // Counter width holds 0..WORDS_PER_BLOCK inclusive (saturating value).
    localparam int CNT_W = 4;
    // Byte-offset bits inside a block: 8 words * 2 bytes = 16 bytes.
    localparam int BLK_OFFS_W = 4;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;

    // Qualified per-cycle events inside FILL.
    logic issue_now;
    logic recv_now;
    logic last_word;

    // Request, receive and completion events, derived from state and counters.
    always_comb begin
        issue_now = 1'b0;
        recv_now  = 1'b0;
        last_word = 1'b0;
        if (state_q == FILL) begin
            issue_now = (issue_cnt_q < CNT_FULL);
            // A valid beyond the 8th word cannot occur in FILL (we leave on
            // the 8th), but the guard keeps recv_cnt from ever exceeding 8.
            recv_now  = bus.memory_data_valid && (recv_cnt_q < CNT_FULL);
            last_word = recv_now && (recv_cnt_q == CNT_LAST);
        end
    end

    // Next-state and counter/base update logic.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        base_d      = base_q;
        case (state_q)
            IDLE: begin
                if (bus.miss_detected) begin
                    // Align the miss address down to its 16-byte block.
                    base_d      = {bus.miss_address[ADDR_W-1:BLK_OFFS_W], {BLK_OFFS_W{1'b0}}};
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                // miss_detected/miss_address are deliberately not looked at
                // here: a fill always runs to completion unless reset.
                if (issue_now) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (recv_now) begin
                    recv_cnt_d = recv_cnt_q + CNT_W'(1);
                end
                if (last_word) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and base registers; reset aborts any fill at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
        end
    end

    // Output decode. fsm_busy is Moore; the array strobes follow the valid.
    always_comb begin
        bus.fsm_busy          = (state_q == FILL);
        bus.fsm_state_dbg     = (state_q == FILL);
        bus.mem_en            = issue_now;
        bus.memory_address    = '0;
        bus.write_data_array  = recv_now;
        bus.cache_word_offset = 3'd0;
        bus.write_tag_array   = last_word;
        bus.fill_done         = last_word;
        // Returned words go straight to the data array without a register.
        bus.fill_data         = bus.memory_data;
        if (issue_now) begin
            // base is block-aligned, so base + 14 never carries out of ADDR_W.
            bus.memory_address = base_q + ADDR_W'({issue_cnt_q, 1'b0});
        end
        if (recv_now) begin
            bus.cache_word_offset = recv_cnt_q[2:0];
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm.
// A cycle n is the interval that starts at posedge n. Inputs are driven 1 time unit
// after that posedge, and outputs are checked on the following negedge. Expected
// behaviour comes from a block-fill model: requests base+2k happen in fill cycles
// 1..8. The k-th returned word goes to offset k. The tag write and done pulse come
// with the 8th word.
module tb_cache_fill_fsm;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Expected data-array write words, in return order.
    logic [15:0] exp_q[$];

    cache_fill_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    cache_fill_fsm #(
        .ADDR_W(16),
        .DATA_W(16),
        .WORDS_PER_BLOCK(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock and reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one miss and the memory returns for it, and checks every cycle.
    // Modes:
    //   0 = fixed 4-cycle memory returning 0xA0+k
    //   1 = random gaps with random data
    //   2 = mode 1 plus a disturbed miss_detected/miss_address during FILL
    // rst_cycle > 0 asserts rst in that fill cycle and ends the task with rst held high.
    task automatic do_fill(input logic [15:0] addr, input int mode, input int rst_cycle);
        int          vcyc[8];
        logic [15:0] wdata[8];
        int          base;
        int          k;
        int          gap;
        bit          done;
        bit          vld;
        bit          exp_en;
        logic [15:0] exp_addr;
        bit          exp_tag;
        logic [15:0] exp_data;

        base = (int'(addr) / 16) * 16;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (mode == 0) begin
                vcyc[i]  = i + 5;
                wdata[i] = 16'h00A0 + 16'(i);
            end else begin
                gap     = $urandom_range(0, 3);
                vcyc[i] = (i == 0) ? 2 + gap : vcyc[i-1] + 1 + gap;
                if (vcyc[i] < i + 2) vcyc[i] = i + 2;
                wdata[i] = 16'($urandom);
            end
            exp_q.push_back(wdata[i]);
        end

        // Cycle 0: the miss is presented while the controller is idle.
        @(posedge clk); #1;
        bus.miss_detected     = 1'b1;
        bus.miss_address      = addr;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'($urandom);
        @(negedge clk);
        checks++;
        if (bus.fsm_busy !== 1'b0 || bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL cycle0_idle addr=%h: busy=%b mem_en=%b required busy=0 mem_en=0",
                     addr, bus.fsm_busy, bus.mem_en);
        end

        k    = 0;
        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clk); #1;
            if (mode == 2) begin
                bus.miss_detected = 1'($urandom_range(0, 1));
                bus.miss_address  = 16'h4000;
            end else begin
                bus.miss_detected = 1'b0;
            end
            vld = (k < 8) && (vcyc[k] == c);
            bus.memory_data_valid = vld;
            bus.memory_data       = vld ? wdata[k] : 16'($urandom);
            if (c == rst_cycle) rst = 1'b1;
            @(negedge clk);

            if (c == rst_cycle) begin
                checks++;
                if (bus.fsm_busy !== 1'b0 || bus.mem_en !== 1'b0 || bus.memory_address !== 16'h0 ||
                    bus.write_data_array !== 1'b0 || bus.cache_word_offset !== 3'd0 ||
                    bus.write_tag_array !== 1'b0 || bus.fill_done !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_abort c=%0d: busy=%b en=%b addr=%h wr=%b off=%0d tag=%b done=%b required all 0",
                             c, bus.fsm_busy, bus.mem_en, bus.memory_address, bus.write_data_array,
                             bus.cache_word_offset, bus.write_tag_array, bus.fill_done);
                end
                done = 1'b1;
            end else begin
                exp_en   = (c <= 8);
                exp_addr = exp_en ? 16'(base + 2 * (c - 1)) : 16'h0;
                exp_tag  = vld && (k == 7);
                checks++;
                if (bus.fsm_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy c=%0d base=%h: got %b required 1", c, base[15:0], bus.fsm_busy);
                end
                checks++;
                if (bus.mem_en !== exp_en || bus.memory_address !== exp_addr) begin
                    errors++;
                    $display("FAIL request c=%0d: mem_en=%b addr=%h required mem_en=%b addr=%h",
                             c, bus.mem_en, bus.memory_address, exp_en, exp_addr);
                end
                checks++;
                if (bus.write_data_array !== vld) begin
                    errors++;
                    $display("FAIL data_write c=%0d: got %b required %b", c, bus.write_data_array, vld);
                end
                checks++;
                if (bus.write_tag_array !== exp_tag || bus.fill_done !== exp_tag) begin
                    errors++;
                    $display("FAIL tag_done c=%0d k=%0d: tag=%b done=%b required %b",
                             c, k, bus.write_tag_array, bus.fill_done, exp_tag);
                end
                if (vld) begin
                    exp_data = exp_q.pop_front();
                    checks++;
                    if (bus.cache_word_offset !== 3'(k) || bus.fill_data !== exp_data) begin
                        errors++;
                        $display("FAIL word k=%0d: offset=%0d data=%h required offset=%0d data=%h",
                                 k, bus.cache_word_offset, bus.fill_data, k, exp_data);
                    end
                    k++;
                end
                if (exp_tag) done = 1'b1;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL fill_timeout base=%h: only %0d words seen, required 8", base[15:0], k);
        end
    endtask

    // Idle cycles with random valid pulses: nothing may be written or requested.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.miss_detected     = 1'b0;
            bus.miss_address      = 16'($urandom);
            bus.memory_data_valid = 1'($urandom_range(0, 1));
            bus.memory_data       = 16'($urandom);
            @(negedge clk);
            checks++;
            if (bus.fsm_busy !== 1'b0 || bus.mem_en !== 1'b0 || bus.write_data_array !== 1'b0 ||
                bus.write_tag_array !== 1'b0 || bus.fill_done !== 1'b0 || bus.memory_address !== 16'h0) begin
                errors++;
                $display("FAIL idle i=%0d: busy=%b en=%b addr=%h wr=%b tag=%b done=%b required all 0",
                         i, bus.fsm_busy, bus.mem_en, bus.memory_address, bus.write_data_array,
                         bus.write_tag_array, bus.fill_done);
            end
        end
    endtask

    task automatic test_reset();
        rst                   = 1'b1;
        bus.miss_detected     = 1'b1;
        bus.miss_address      = 16'h1234;
        bus.memory_data_valid = 1'b1;
        bus.memory_data       = 16'h5A5A;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.fsm_busy !== 1'b0 || bus.mem_en !== 1'b0 || bus.memory_address !== 16'h0 ||
            bus.write_data_array !== 1'b0 || bus.cache_word_offset !== 3'd0 ||
            bus.write_tag_array !== 1'b0 || bus.fill_done !== 1'b0 || bus.fsm_state_dbg !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b en=%b addr=%h wr=%b off=%0d tag=%b done=%b required all 0",
                     bus.fsm_busy, bus.mem_en, bus.memory_address, bus.write_data_array,
                     bus.cache_word_offset, bus.write_tag_array, bus.fill_done);
        end
        checks++;
        if (bus.fill_data !== 16'h5A5A) begin
            errors++;
            $display("FAIL fill_passthru: got %h required 5a5a", bus.fill_data);
        end
        @(posedge clk); #1;
        rst               = 1'b0;
        bus.miss_detected = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_basic_fill();
        do_fill(16'h1234, 0, -1);
        idle_cycles(2);
    endtask

    task automatic test_top_of_memory();
        do_fill(16'hFFFF, 1, -1);
        idle_cycles(2);
    endtask

    task automatic test_irregular_valids();
        for (int i = 0; i < 4; i++) begin
            do_fill(16'($urandom), 1, -1);
            idle_cycles(1);
        end
    endtask

    task automatic test_ignore_inputs();
        do_fill(16'h8ABC, 2, -1);
        idle_cycles(6);
    endtask

    task automatic test_reset_mid_fill();
        do_fill(16'h5678, 0, 6);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(3);
        do_fill(16'h2000, 1, -1);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        // The second call drives its miss in the cycle right after the done
        // pulse, so miss stays high from cycle 13 and busy drops for one cycle.
        do_fill(16'h3456, 0, -1);
        do_fill(16'h789A, 1, -1);
        do_fill(16'hC00E, 0, -1);
        idle_cycles(2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_fill();
        test_top_of_memory();
        test_irregular_valids();
        test_ignore_inputs();
        test_reset_mid_fill();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
